// File: rtl/urv_writeback.sv
// Writeback stage: commits ALU results or formatted load data into the register file.
// Latency: ALU results commit one cycle after accept; loads commit the cycle after dm_load_done_i.
// Backpressure: w_stall_o is high only while waiting for load data (URV_WB_LOAD_TIMEOUT_EN adds a load timeout).
module urv_writeback #(
    parameter int g_timeout = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic        x_rd_write_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_load_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_i,
    input  logic        dm_load_done_i,
    input  logic [31:0] dm_data_l_i,
    output logic        w_stall_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_store_o,
    output logic        rf_bypass_write_o,
    output logic [31:0] rf_bypass_value_o,
    output logic        w_load_err_o
);

    typedef enum logic [1:0] {IDLE, ALU_COMMIT, LOAD_WAIT, LOAD_COMMIT} state_t;

    if (g_timeout < 1 || g_timeout > 255) begin : g_timeout_range
        $error("urv_writeback: g_timeout must be within 1..255");
    end

    state_t      state;
    logic [4:0]  rd_q;
    logic [31:0] value_q;
    logic        store_q;
    logic        wen_q;
    logic [2:0]  fun_q;
    logic [1:0]  addr_q;
    logic        accept;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_fmt;

`ifdef URV_WB_LOAD_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(g_timeout - 1);
    logic [7:0] tmo_cnt;
    logic       err_q;
    assign w_load_err_o = err_q;
`else
    assign w_load_err_o = 1'b0;
`endif

    assign w_stall_o         = (state == LOAD_WAIT);
    assign accept            = x_valid_i & ~w_stall_o;
    assign rf_rd_o           = rd_q;
    assign rf_rd_value_o     = value_q;
    assign rf_bypass_value_o = value_q;
    assign rf_rd_store_o     = store_q;
    assign rf_bypass_write_o = store_q;

    // Halfword selection looks only at addr[1]; misaligned halfwords read the containing half.
    always_comb begin
        ld_byte = dm_data_l_i[7:0];
        case (addr_q)
            2'd1:    ld_byte = dm_data_l_i[15:8];
            2'd2:    ld_byte = dm_data_l_i[23:16];
            2'd3:    ld_byte = dm_data_l_i[31:24];
            default: ld_byte = dm_data_l_i[7:0];
        endcase
        ld_half = addr_q[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
        case (fun_q)
            3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_fmt = {24'd0, ld_byte};
            3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_fmt = {16'd0, ld_half};
            default: load_fmt = dm_data_l_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            rd_q    <= 5'd0;
            value_q <= 32'd0;
            store_q <= 1'b0;
            wen_q   <= 1'b0;
            fun_q   <= 3'd0;
            addr_q  <= 2'd0;
`ifdef URV_WB_LOAD_TIMEOUT_EN
            tmo_cnt <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            store_q <= 1'b0;
`ifdef URV_WB_LOAD_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state)
                LOAD_WAIT: begin
                    // Real data wins over a timeout expiring in the same cycle.
                    if (dm_load_done_i) begin
                        value_q <= load_fmt;
                        store_q <= wen_q;
                        state   <= LOAD_COMMIT;
                    end
`ifdef URV_WB_LOAD_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        value_q <= 32'd0;
                        store_q <= wen_q;
                        err_q   <= 1'b1;
                        state   <= LOAD_COMMIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    if (accept) begin
                        rd_q <= x_rd_i;
                        if (x_load_i) begin
                            wen_q  <= x_rd_write_i && (x_rd_i != 5'd0);
                            fun_q  <= x_fun_i;
                            addr_q <= x_dm_addr_i;
                            state  <= LOAD_WAIT;
`ifdef URV_WB_LOAD_TIMEOUT_EN
                            tmo_cnt <= 8'd0;
`endif
                        end else begin
                            value_q <= x_rd_value_i;
                            store_q <= x_rd_write_i && (x_rd_i != 5'd0);
                            state   <= ALU_COMMIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_urv_writeback.sv
// Directed bench for urv_writeback; exercises the timeout path when URV_WB_LOAD_TIMEOUT_EN is defined.
module tb_urv_writeback;

    logic        clk_i;
    logic        rst_i;
    logic        x_valid_i;
    logic [4:0]  x_rd_i;
    logic        x_rd_write_i;
    logic [31:0] x_rd_value_i;
    logic        x_load_i;
    logic [2:0]  x_fun_i;
    logic [1:0]  x_dm_addr_i;
    logic        dm_load_done_i;
    logic [31:0] dm_data_l_i;
    logic        w_stall_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_store_o;
    logic        rf_bypass_write_o;
    logic [31:0] rf_bypass_value_o;
    logic        w_load_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    urv_writeback #(.g_timeout(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .x_valid_i(x_valid_i), .x_rd_i(x_rd_i), .x_rd_write_i(x_rd_write_i),
        .x_rd_value_i(x_rd_value_i), .x_load_i(x_load_i), .x_fun_i(x_fun_i),
        .x_dm_addr_i(x_dm_addr_i), .dm_load_done_i(dm_load_done_i), .dm_data_l_i(dm_data_l_i),
        .w_stall_o(w_stall_o), .rf_rd_o(rf_rd_o), .rf_rd_value_o(rf_rd_value_o),
        .rf_rd_store_o(rf_rd_store_o), .rf_bypass_write_o(rf_bypass_write_o),
        .rf_bypass_value_o(rf_bypass_value_o), .w_load_err_o(w_load_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic wr, input logic [31:0] val,
                         input logic ld, input logic [2:0] fun, input logic [1:0] addr);
        x_valid_i = v; x_rd_i = rd; x_rd_write_i = wr; x_rd_value_i = val;
        x_load_i = ld; x_fun_i = fun; x_dm_addr_i = addr;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; dm_load_done_i = 1'b1; dm_data_l_i = 32'hFFFF_FFFF;
        drive(1'b1, 5'd3, 1'b1, 32'hA5A5_A5A5, 1'b0, 3'd2, 2'd0);
        #12;
        n_checks++; if (w_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", w_stall_o); end
        n_checks++; if (rf_rd_o !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", rf_rd_o); end
        n_checks++; if (rf_rd_value_o !== 32'd0) begin n_fail++; $display("FAIL reset_value: got %h want 0", rf_rd_value_o); end
        n_checks++; if (rf_rd_store_o !== 1'b0) begin n_fail++; $display("FAIL reset_store: got %b want 0", rf_rd_store_o); end
        n_checks++; if (rf_bypass_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_bypass_wr: got %b want 0", rf_bypass_write_o); end
        n_checks++; if (rf_bypass_value_o !== 32'd0) begin n_fail++; $display("FAIL reset_bypass_val: got %h want 0", rf_bypass_value_o); end
        n_checks++; if (w_load_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", w_load_err_o); end
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        dm_load_done_i = 1'b0; dm_data_l_i = 32'd0;
        rst_i = 1'b1;
    endtask

    // Called immediately after reset release: the first edge must already accept.
    task automatic test_alu();
        drive(1'b1, 5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'd0, 2'd0);
        n_checks++; if (w_stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall_pre: got %b want 0", w_stall_o); end
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        n_checks++; if (rf_rd_store_o !== 1'b1) begin n_fail++; $display("FAIL alu_store: got %b want 1", rf_rd_store_o); end
        n_checks++; if (rf_bypass_write_o !== 1'b1) begin n_fail++; $display("FAIL alu_bypass_wr: got %b want 1", rf_bypass_write_o); end
        n_checks++; if (rf_rd_o !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d want 5", rf_rd_o); end
        n_checks++; if (rf_rd_value_o !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_value: got %h want 12345678", rf_rd_value_o); end
        n_checks++; if (rf_bypass_value_o !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_bypass_val: got %h want 12345678", rf_bypass_value_o); end
        n_checks++; if (w_stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", w_stall_o); end
        tick();
        n_checks++; if (rf_rd_store_o !== 1'b0) begin n_fail++; $display("FAIL alu_one_cycle: got %b want 0", rf_rd_store_o); end
        n_checks++; if (rf_rd_o !== 5'd5) begin n_fail++; $display("FAIL alu_rd_hold: got %0d want 5", rf_rd_o); end
        drive(1'b1, 5'd7, 1'b0, 32'h0000_0042, 1'b0, 3'd0, 2'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        n_checks++; if (rf_rd_store_o !== 1'b0) begin n_fail++; $display("FAIL alu_nowrite_store: got %b want 0", rf_rd_store_o); end
        n_checks++; if (rf_rd_o !== 5'd7) begin n_fail++; $display("FAIL alu_nowrite_rd: got %0d want 7", rf_rd_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds [3] = '{5'd1, 5'd2, 5'd3};
        logic [31:0] vals[3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rds[i], 1'b1, vals[i], 1'b0, 3'd0, 2'd0);
            tick();
            n_checks++; if (rf_rd_store_o !== 1'b1 || rf_rd_o !== rds[i] || rf_rd_value_o !== vals[i])
                begin n_fail++; $display("FAIL b2b_%0d: got st=%b rd=%0d val=%h want st=1 rd=%0d val=%h", i, rf_rd_store_o, rf_rd_o, rf_rd_value_o, rds[i], vals[i]); end
            n_checks++; if (w_stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_%0d: got %b want 0", i, w_stall_o); end
        end
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        tick();
    endtask

    task automatic test_load_format();
        logic [2:0]  fun [8] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b000, 3'b001, 3'b010, 3'b011};
        logic [1:0]  addr[8] = '{2'd3, 2'd2, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
        logic [31:0] mem [8] = '{32'h80FF_0000, 32'h80FF_0000, 32'h0000_FFFF, 32'h1234_5678,
                                 32'h0000_007F, 32'h8001_1234, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        logic [31:0] expv[8] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_FFFF, 32'h0000_0056,
                                 32'h0000_007F, 32'hFFFF_8001, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'd9, 1'b1, 32'h5555_5555, 1'b1, fun[i], addr[i]);
            tick();
            drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
            n_checks++; if (w_stall_o !== 1'b1) begin n_fail++; $display("FAIL ldfmt_stall_%0d: got %b want 1", i, w_stall_o); end
            dm_load_done_i = 1'b1; dm_data_l_i = mem[i];
            tick();
            dm_load_done_i = 1'b0; dm_data_l_i = 32'd0;
            n_checks++; if (rf_rd_store_o !== 1'b1 || rf_rd_value_o !== expv[i] || rf_bypass_value_o !== expv[i])
                begin n_fail++; $display("FAIL ldfmt_%0d: got st=%b val=%h byp=%h want st=1 val=%h", i, rf_rd_store_o, rf_rd_value_o, rf_bypass_value_o, expv[i]); end
            n_checks++; if (w_stall_o !== 1'b0) begin n_fail++; $display("FAIL ldfmt_commit_stall_%0d: got %b want 0", i, w_stall_o); end
            tick();
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 5'd4, 1'b1, 32'd0, 1'b1, 3'b010, 2'd0);
        tick();
        // Offers made during the stall must be ignored.
        drive(1'b1, 5'd31, 1'b1, 32'hBAD0_BAD0, 1'b0, 3'd0, 2'd0);
        for (int c = 1; c <= 5; c++) begin
            n_checks++; if (w_stall_o !== 1'b1 || rf_rd_store_o !== 1'b0)
                begin n_fail++; $display("FAIL stall_cycle_%0d: got stall=%b st=%b want stall=1 st=0", c, w_stall_o, rf_rd_store_o); end
            if (c == 5) begin dm_load_done_i = 1'b1; dm_data_l_i = 32'h0BAD_F00D; end
            if (c < 5) tick();
        end
        tick();
        dm_load_done_i = 1'b0; dm_data_l_i = 32'd0;
        n_checks++; if (rf_rd_store_o !== 1'b1 || rf_rd_o !== 5'd4 || rf_rd_value_o !== 32'h0BAD_F00D || w_stall_o !== 1'b0)
            begin n_fail++; $display("FAIL stall_commit: got st=%b rd=%0d val=%h stall=%b want st=1 rd=4 val=0badf00d stall=0", rf_rd_store_o, rf_rd_o, rf_rd_value_o, w_stall_o); end
        drive(1'b1, 5'd6, 1'b1, 32'h55AA_55AA, 1'b0, 3'd0, 2'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        n_checks++; if (rf_rd_store_o !== 1'b1 || rf_rd_o !== 5'd6 || rf_rd_value_o !== 32'h55AA_55AA)
            begin n_fail++; $display("FAIL stall_b2b_alu: got st=%b rd=%0d val=%h want st=1 rd=6 val=55aa55aa", rf_rd_store_o, rf_rd_o, rf_rd_value_o); end
        tick();
        dm_load_done_i = 1'b1; dm_data_l_i = 32'hFFFF_0000;
        tick();
        dm_load_done_i = 1'b0;
        n_checks++; if (rf_rd_store_o !== 1'b0 || rf_rd_value_o !== 32'h55AA_55AA || w_stall_o !== 1'b0)
            begin n_fail++; $display("FAIL stray_done: got st=%b val=%h stall=%b want st=0 val=55aa55aa stall=0", rf_rd_store_o, rf_rd_value_o, w_stall_o); end
    endtask

    task automatic test_rd_zero();
        drive(1'b1, 5'd0, 1'b1, 32'h7777_7777, 1'b0, 3'd0, 2'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        n_checks++; if (rf_rd_store_o !== 1'b0 || rf_bypass_write_o !== 1'b0)
            begin n_fail++; $display("FAIL x0_alu: got st=%b byp=%b want 0 0", rf_rd_store_o, rf_bypass_write_o); end
        drive(1'b1, 5'd0, 1'b1, 32'd0, 1'b1, 3'b010, 2'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (w_stall_o !== 1'b1) begin n_fail++; $display("FAIL x0_load_stall_%0d: got %b want 1", c, w_stall_o); end
            if (c < 2) tick();
        end
        dm_load_done_i = 1'b1; dm_data_l_i = 32'h1234_ABCD;
        tick();
        dm_load_done_i = 1'b0;
        n_checks++; if (rf_rd_store_o !== 1'b0 || rf_bypass_write_o !== 1'b0 || w_stall_o !== 1'b0)
            begin n_fail++; $display("FAIL x0_load_commit: got st=%b byp=%b stall=%b want 0 0 0", rf_rd_store_o, rf_bypass_write_o, w_stall_o); end
        tick();
    endtask

    task automatic test_reset_mid_load();
        drive(1'b1, 5'd8, 1'b1, 32'd0, 1'b1, 3'b010, 2'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        tick();
        n_checks++; if (w_stall_o !== 1'b1) begin n_fail++; $display("FAIL rstload_stall: got %b want 1", w_stall_o); end
        rst_i = 1'b0;
        #1;
        n_checks++; if (w_stall_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_rd_value_o !== 32'd0 || rf_rd_store_o !== 1'b0)
            begin n_fail++; $display("FAIL rstload_outputs: got stall=%b rd=%0d val=%h st=%b want all 0", w_stall_o, rf_rd_o, rf_rd_value_o, rf_rd_store_o); end
        dm_load_done_i = 1'b1; dm_data_l_i = 32'hDDDD_DDDD;
        tick();
        n_checks++; if (rf_rd_store_o !== 1'b0 || rf_bypass_write_o !== 1'b0 || rf_bypass_value_o !== 32'd0)
            begin n_fail++; $display("FAIL rstload_hold: got st=%b byp=%b bval=%h want 0 0 0", rf_rd_store_o, rf_bypass_write_o, rf_bypass_value_o); end
        rst_i = 1'b1;
        tick();
        dm_load_done_i = 1'b0;
        n_checks++; if (rf_rd_store_o !== 1'b0 || rf_rd_value_o !== 32'd0 || w_stall_o !== 1'b0)
            begin n_fail++; $display("FAIL rstload_late_done: got st=%b val=%h stall=%b want 0 0 0", rf_rd_store_o, rf_rd_value_o, w_stall_o); end
        tick();
    endtask

`ifdef URV_WB_LOAD_TIMEOUT_EN
    task automatic test_timeout();
        drive(1'b1, 5'd10, 1'b1, 32'd0, 1'b1, 3'b010, 2'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        for (int c = 1; c <= 4; c++) begin
            n_checks++; if (w_stall_o !== 1'b1 || w_load_err_o !== 1'b0)
                begin n_fail++; $display("FAIL tmo_wait_%0d: got stall=%b err=%b want 1 0", c, w_stall_o, w_load_err_o); end
            tick();
        end
        n_checks++; if (rf_rd_store_o !== 1'b1 || rf_rd_value_o !== 32'd0 || w_load_err_o !== 1'b1 || w_stall_o !== 1'b0)
            begin n_fail++; $display("FAIL tmo_commit: got st=%b val=%h err=%b stall=%b want 1 0 1 0", rf_rd_store_o, rf_rd_value_o, w_load_err_o, w_stall_o); end
        tick();
        n_checks++; if (w_load_err_o !== 1'b0 || rf_rd_store_o !== 1'b0)
            begin n_fail++; $display("FAIL tmo_err_pulse: got err=%b st=%b want 0 0", w_load_err_o, rf_rd_store_o); end
        drive(1'b1, 5'd11, 1'b1, 32'd0, 1'b1, 3'b010, 2'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        tick(); tick(); tick();
        dm_load_done_i = 1'b1; dm_data_l_i = 32'h1357_9BDF;
        tick();
        dm_load_done_i = 1'b0;
        n_checks++; if (rf_rd_store_o !== 1'b1 || rf_rd_value_o !== 32'h1357_9BDF || w_load_err_o !== 1'b0)
            begin n_fail++; $display("FAIL tmo_done_priority: got st=%b val=%h err=%b want 1 13579bdf 0", rf_rd_store_o, rf_rd_value_o, w_load_err_o); end
        tick();
    endtask
`else
    task automatic test_timeout();
        drive(1'b1, 5'd10, 1'b1, 32'd0, 1'b1, 3'b010, 2'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        for (int c = 1; c <= 10; c++) begin
            n_checks++; if (w_stall_o !== 1'b1 || w_load_err_o !== 1'b0 || rf_rd_store_o !== 1'b0)
                begin n_fail++; $display("FAIL notmo_wait_%0d: got stall=%b err=%b st=%b want 1 0 0", c, w_stall_o, w_load_err_o, rf_rd_store_o); end
            tick();
        end
        dm_load_done_i = 1'b1; dm_data_l_i = 32'h1357_9BDF;
        tick();
        dm_load_done_i = 1'b0;
        n_checks++; if (rf_rd_store_o !== 1'b1 || rf_rd_value_o !== 32'h1357_9BDF || w_load_err_o !== 1'b0)
            begin n_fail++; $display("FAIL notmo_commit: got st=%b val=%h err=%b want 1 13579bdf 0", rf_rd_store_o, rf_rd_value_o, w_load_err_o); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_format();
        test_stall();
        test_rd_zero();
        test_reset_mid_load();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/urv_writeback.md
URV_WRITEBACK -- requirements
Module: urv_writeback

Interface
REQ-001 Parameter: g_timeout, 255, LOAD_WAIT cycles before a load is abandoned (used only with URV_WB_LOAD_TIMEOUT_EN); legal range 1..255.
REQ-002 The block SHALL use clock clk_i and reset rst_i; rst_i is asynchronous and active-low.
REQ-003 Ports (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  async reset, active-low
- x_valid_i  in  1  execute stage offers an instruction
- x_rd_i  in  5  destination register
- x_rd_write_i  in  1  instruction writes rd
- x_rd_value_i  in  32  ALU result
- x_load_i  in  1  instruction is a load
- x_fun_i  in  3  load funct3
- x_dm_addr_i  in  2  load address bits [1:0]
- dm_load_done_i  in  1  data memory load data valid
- dm_data_l_i  in  32  data memory read word
- w_stall_o  out  1  back-pressure to execute stage
- rf_rd_o  out  5  register-file write address
- rf_rd_value_o  out  32  register-file write data
- rf_rd_store_o  out  1  register-file write strobe
- rf_bypass_write_o  out  1  bypass valid towards decode/execute
- rf_bypass_value_o  out  32  bypass data
- w_load_err_o  out  1  load timeout pulse

Function
REQ-004 The block SHALL accept an instruction in any cycle where x_valid_i=1 and w_stall_o=0, and SHALL ignore x_* inputs otherwise.
REQ-005 The block SHALL have states IDLE, ALU_COMMIT, LOAD_WAIT, LOAD_COMMIT.
REQ-006 On accept with x_load_i=0, it SHALL go to ALU_COMMIT; with x_load_i=1, to LOAD_WAIT; with no accept, to IDLE.
REQ-007 In ALU_COMMIT, it SHALL drive rf_rd_store_o=rf_bypass_write_o=captured x_rd_write_i AND (rd!=0) for exactly one cycle, with rf_rd_value_o=rf_bypass_value_o=captured x_rd_value_i (latency: one cycle after accept).
REQ-008 In LOAD_WAIT, w_stall_o SHALL be 1; when dm_load_done_i=1, it SHALL register the formatted word and go to LOAD_COMMIT next cycle.
REQ-009 In LOAD_COMMIT, it SHALL behave as ALU_COMMIT with the formatted load word; w_stall_o=0, so a new accept is possible in the same cycle.
REQ-010 w_stall_o SHALL be 0 in IDLE, ALU_COMMIT and LOAD_COMMIT; back-to-back ALU instructions sustain one commit per cycle.
REQ-011 Load formatting SHALL be:
- 000 LB: sign-extend byte addr[1:0].
- 100 LBU: zero-extend byte addr[1:0].
- 001 LH: sign-extend halfword addr[1].
- 101 LHU: zero-extend halfword addr[1].
- Any other code: full word.
- addr[0] SHALL be ignored for halfwords.
REQ-012 dm_load_done_i outside LOAD_WAIT SHALL be ignored.
REQ-013 A load to rd=0 SHALL still wait for dm_load_done_i, then produce no strobe.
REQ-014 rf_rd_o SHALL hold the captured rd from accept until the next accept.

Reset
REQ-015 While rst_i=0, the state SHALL be IDLE and all outputs SHALL be 0; the same applies if asserted mid-load, with no commit occurring for the pending load.
REQ-016 After rst_i deasserts, the first accept SHALL be possible on the first clock edge.

Configuration
REQ-017 With URV_WB_LOAD_TIMEOUT_EN defined, an 8-bit counter SHALL clear on LOAD_WAIT entry and increment every LOAD_WAIT cycle without dm_load_done_i. On reaching g_timeout, the block SHALL go to LOAD_COMMIT with data 0 and pulse w_load_err_o for one cycle, coincident with that commit. dm_load_done_i in the expiry cycle SHALL take priority: normal data, no error.
REQ-018 Without URV_WB_LOAD_TIMEOUT_EN, LOAD_WAIT SHALL persist until dm_load_done_i, no counter SHALL exist, and w_load_err_o SHALL be constant 0.

Verification
REQ-019 The bench SHALL cover the following scenarios:
- ALU path: accept rd=5, value 0x12345678, write=1 -> next cycle store=bypass=1, rf_rd_o=5, value 0x12345678, w_stall_o=0 throughout.
- Load format: LB addr=3, memory 0x80FF0000 -> commit 0xFFFFFF80; LHU addr=2 -> 0x000080FF; LH addr=1 -> 0xFFFFFFFF on memory 0x0000FFFF.
- Stall: load with done delayed 4 cycles -> w_stall_o=1 for 5 cycles, commit in the cycle after done, a back-to-back ALU instruction accepted in the commit cycle.
- rd=0: ALU and load to x0 -> no rf_rd_store_o/rf_bypass_write_o; the load still stalls until done.
- Reset mid-LOAD_WAIT: rst_i low -> all outputs 0, no commit; done arriving afterwards is ignored.
- Timeout (macro on, g_timeout=4): no done -> after 4 LOAD_WAIT cycles, commit value 0 with w_load_err_o=1 for one cycle; done exactly at expiry -> real data, w_load_err_o=0.
